// File: rtl/toeplitz_router_pkg.sv
// Shared state type, stride encodings and config legality check for toeplitz_router.
package toeplitz_router_pkg;

  typedef enum logic [0:0] {S_IDLE, S_STREAM} router_state_t;

  localparam logic [1:0] STRIDE_1 = 2'd1;
  localparam logic [1:0] STRIDE_2 = 2'd2;
  localparam int unsigned CNT_W = 16;

  // iw_pad is the ifmap side including both padded borders.
  function automatic logic cfg_legal(input logic [3:0] k, input logic [1:0] s,
                                     input logic [16:0] iw_pad, input int unsigned max_k);
    return (k != 4'd0) && (32'(k) <= max_k) && ((s == STRIDE_1) || (s == STRIDE_2)) &&
           (iw_pad >= 17'(k));
  endfunction

endpackage

// File: rtl/ofmap_pos_counter.sv
// Row-major output-position counter: ox inner, oy outer, square limit x limit.
module ofmap_pos_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clear,
  input  logic             advance,
  input  logic [Width-1:0] limit,
  output logic [Width-1:0] ox,
  output logic [Width-1:0] oy,
  output logic             last
);

  logic [Width-1:0] ox_q, oy_q, top;

  assign top  = limit - Width'(1);
  assign last = (ox_q == top) && (oy_q == top);
  assign ox   = ox_q;
  assign oy   = oy_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ox_q <= '0;
      oy_q <= '0;
    end else if (clear) begin
      ox_q <= '0;
      oy_q <= '0;
    end else if (advance) begin
      if (ox_q == top) begin
        ox_q <= '0;
        oy_q <= oy_q + Width'(1);
      end else begin
        ox_q <= ox_q + Width'(1);
      end
    end
  end

endmodule

// File: rtl/toeplitz_router.sv
// Ifmap register file streaming im2col windows with valid/ready backpressure.
// Optional zero padding (cfg_pad port) enabled by TOEPLITZ_ROUTER_PAD_EN.
module toeplitz_router
  import toeplitz_router_pkg::*;
#(
  parameter int unsigned dataSize       = 8,
  parameter int unsigned numRegister    = 256,
  parameter int unsigned nElementsOut   = 9,
  parameter int unsigned maxKernelWidth = 3,
  localparam int unsigned nAddress      = $clog2(numRegister)
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic [dataSize-1:0]              wr_data,
  input  logic [nAddress-1:0]              wr_addr,
  input  logic                             wr_en,
  input  logic [15:0]                      cfg_ifmap_width,
  input  logic [3:0]                       cfg_kernel_width,
  input  logic [1:0]                       cfg_stride,
`ifdef TOEPLITZ_ROUTER_PAD_EN
  input  logic                             cfg_pad,
`endif
  input  logic                             ctrl_start,
  output logic [dataSize*nElementsOut-1:0] rd_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             flag_busy,
  output logic                             flag_done,
  output logic                             flag_cfg_err
);

  logic [dataSize-1:0] regs_q [numRegister];
  router_state_t state_q;
  logic [15:0] iw_q;
  logic [3:0]  k_q;
  logic [1:0]  s_q;
  logic        p_q, pad, start_legal, start_accept;
  logic [16:0] iw_pad, span;
  logic [CNT_W-1:0] ow, ox, oy;
  logic last, load_en, drained_q, out_valid_q, done_q, cfg_err_q;
  logic [nElementsOut-1:0][dataSize-1:0] win, rd_data_q;
  int lane, x, y, addr;

`ifdef TOEPLITZ_ROUTER_PAD_EN
  assign pad = cfg_pad;
`else
  assign pad = 1'b0;
`endif

  assign iw_pad       = 17'(cfg_ifmap_width) + (pad ? 17'd2 : 17'd0);
  assign start_legal  = cfg_legal(cfg_kernel_width, cfg_stride, iw_pad, maxKernelWidth);
  assign start_accept = (state_q == S_IDLE) && ctrl_start && start_legal;
  // drained_q: the last window has been loaded, only its handshake remains.
  assign load_en      = (state_q == S_STREAM) && !drained_q && (!out_valid_q || out_ready);

  always_comb begin
    span = 17'(iw_q) + (p_q ? 17'd2 : 17'd0) - 17'(k_q);
    if (s_q == STRIDE_2) span = span >> 1;
    ow = 16'(span) + 16'd1;
  end

  ofmap_pos_counter #(
    .Width(CNT_W)
  ) u_pos (
    .clk    (clk),
    .nrst   (nrst),
    .clear  (start_accept),
    .advance(load_en && !last),
    .limit  (ow),
    .ox     (ox),
    .oy     (oy),
    .last   (last)
  );

  always_comb begin
    win  = '0;
    lane = 0;
    x    = 0;
    y    = 0;
    addr = 0;
    for (int j = 0; j < int'(maxKernelWidth); j++) begin
      for (int i = 0; i < int'(maxKernelWidth); i++) begin
        if ((i < int'(k_q)) && (j < int'(k_q))) begin
          lane = j * int'(k_q) + i;
          x    = int'(ox) * ((s_q == STRIDE_2) ? 2 : 1) + i - int'(p_q);
          y    = int'(oy) * ((s_q == STRIDE_2) ? 2 : 1) + j - int'(p_q);
          if ((x >= 0) && (x < int'(iw_q)) && (y >= 0) && (y < int'(iw_q))) begin
            addr = y * int'(iw_q) + x;
            if ((addr < int'(numRegister)) && (lane < int'(nElementsOut))) begin
              win[lane] = regs_q[nAddress'(addr)];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int a = 0; a < int'(numRegister); a++) regs_q[a] <= '0;
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      iw_q        <= '0;
      k_q         <= '0;
      s_q         <= '0;
      p_q         <= 1'b0;
      rd_data_q   <= '0;
      out_valid_q <= 1'b0;
      drained_q   <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ctrl_start) begin
            if (start_legal) begin
              state_q   <= S_STREAM;
              iw_q      <= cfg_ifmap_width;
              k_q       <= cfg_kernel_width;
              s_q       <= cfg_stride;
              p_q       <= pad;
              drained_q <= 1'b0;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (load_en) begin
            rd_data_q   <= win;
            out_valid_q <= 1'b1;
            drained_q   <= last;
          end else if (out_valid_q && out_ready && drained_q) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_data      = rd_data_q;
  assign out_valid    = out_valid_q;
  assign flag_busy    = (state_q == S_STREAM);
  assign flag_done    = done_q;
  assign flag_cfg_err = cfg_err_q;

endmodule

// File: tb/tb_toeplitz_router.sv
// Directed bench for toeplitz_router; pad cases built when TOEPLITZ_ROUTER_PAD_EN is defined.
module tb_toeplitz_router;

  localparam int unsigned DW = 8;
  localparam int unsigned NE = 9;
  localparam int unsigned OW = DW * NE;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [7:0]    wr_addr = '0;
  logic          wr_en = 1'b0;
  logic [15:0]   cfg_ifmap_width = '0;
  logic [3:0]    cfg_kernel_width = '0;
  logic [1:0]    cfg_stride = '0;
`ifdef TOEPLITZ_ROUTER_PAD_EN
  logic          cfg_pad = 1'b0;
`endif
  logic          ctrl_start = 1'b0;
  logic [OW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          flag_busy, flag_done, flag_cfg_err;

  int n_checks = 0;
  int n_fail = 0;
  logic [OW-1:0] exp_q[$];

  toeplitz_router #(
    .dataSize      (DW),
    .numRegister   (256),
    .nElementsOut  (NE),
    .maxKernelWidth(3)
  ) dut (
    .clk             (clk),
    .nrst            (nrst),
    .wr_data         (wr_data),
    .wr_addr         (wr_addr),
    .wr_en           (wr_en),
    .cfg_ifmap_width (cfg_ifmap_width),
    .cfg_kernel_width(cfg_kernel_width),
    .cfg_stride      (cfg_stride),
`ifdef TOEPLITZ_ROUTER_PAD_EN
    .cfg_pad         (cfg_pad),
`endif
    .ctrl_start      (ctrl_start),
    .rd_data         (rd_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .flag_busy       (flag_busy),
    .flag_done       (flag_done),
    .flag_cfg_err    (flag_cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] win9(input int a0, input int a1, input int a2,
                                         input int a3, input int a4, input int a5,
                                         input int a6, input int a7, input int a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_ramp();
    for (int a = 0; a < 256; a++) begin
      wr_en   = 1'b1;
      wr_addr = 8'(a);
      wr_data = 8'(a);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic start_cfg(input int iw, input int k, input int s);
    cfg_ifmap_width  = 16'(iw);
    cfg_kernel_width = 4'(k);
    cfg_stride       = 2'(s);
    ctrl_start       = 1'b1;
  endtask

  // Expects start_cfg already applied and out_ready high; checks every window of exp_q.
  task automatic run_stream(input string tag);
    tick();
    ctrl_start = 1'b0;
    check_eq({tag, " busy"}, OW'(flag_busy), OW'(1));
    check_eq({tag, " latency"}, OW'(out_valid), OW'(0));
    for (int w = 0; w < exp_q.size(); w++) begin
      tick();
      check_eq($sformatf("%s valid w%0d", tag, w), OW'(out_valid), OW'(1));
      check_eq($sformatf("%s data w%0d", tag, w), rd_data, exp_q[w]);
    end
    tick();
    check_eq({tag, " end valid"}, OW'(out_valid), OW'(0));
    check_eq({tag, " done"}, OW'(flag_done), OW'(1));
    check_eq({tag, " end busy"}, OW'(flag_busy), OW'(0));
    tick();
    check_eq({tag, " done pulse"}, OW'(flag_done), OW'(0));
  endtask

  initial begin
    tick();
    tick();
    check_eq("reset data", rd_data, '0);
    check_eq("reset flags", OW'({out_valid, flag_busy, flag_done, flag_cfg_err}), OW'(0));
    nrst = 1'b1;
    tick();
    write_ramp();

    // iw=4 k=3 s=1
    exp_q = '{win9(0, 1, 2, 4, 5, 6, 8, 9, 10), win9(1, 2, 3, 5, 6, 7, 9, 10, 11),
              win9(4, 5, 6, 8, 9, 10, 12, 13, 14), win9(5, 6, 7, 9, 10, 11, 13, 14, 15)};
    start_cfg(4, 3, 1);
    run_stream("k3s1");

    // Backpressure on the second window; a start during the stall is ignored.
    start_cfg(4, 3, 1);
    tick();
    ctrl_start = 1'b0;
    tick();
    check_eq("bp w0", rd_data, exp_q[0]);
    tick();
    check_eq("bp w1", rd_data, exp_q[1]);
    out_ready  = 1'b0;
    ctrl_start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      ctrl_start = 1'b0;
      check_eq($sformatf("bp hold valid %0d", c), OW'(out_valid), OW'(1));
      check_eq($sformatf("bp hold data %0d", c), rd_data, exp_q[1]);
    end
    out_ready = 1'b1;
    tick();
    check_eq("bp w2", rd_data, exp_q[2]);
    tick();
    check_eq("bp w3", rd_data, exp_q[3]);
    tick();
    check_eq("bp done", OW'({flag_done, out_valid, flag_busy}), OW'(3'b100));

    // iw=5 k=3 s=2
    exp_q = '{win9(0, 1, 2, 5, 6, 7, 10, 11, 12), win9(2, 3, 4, 7, 8, 9, 12, 13, 14),
              win9(10, 11, 12, 15, 16, 17, 20, 21, 22), win9(12, 13, 14, 17, 18, 19, 22, 23, 24)};
    start_cfg(5, 3, 2);
    run_stream("k3s2");

    // iw=3 k=2 s=1: lanes 4..8 stay zero
    exp_q = '{win9(0, 1, 3, 4, 0, 0, 0, 0, 0), win9(1, 2, 4, 5, 0, 0, 0, 0, 0),
              win9(3, 4, 6, 7, 0, 0, 0, 0, 0), win9(4, 5, 7, 8, 0, 0, 0, 0, 0)};
    start_cfg(3, 2, 1);
    run_stream("k2s1");

    // Illegal configs: k too large, stride 3, k=0.
    for (int t = 0; t < 3; t++) begin
      if (t == 0) start_cfg(4, 4, 1);
      else if (t == 1) start_cfg(4, 3, 3);
      else start_cfg(4, 0, 1);
      tick();
      ctrl_start = 1'b0;
      check_eq($sformatf("cfg_err pulse %0d", t), OW'({flag_cfg_err, out_valid, flag_busy}),
               OW'(3'b100));
      tick();
      check_eq($sformatf("cfg_err after %0d", t),
               OW'({flag_cfg_err, out_valid, flag_busy, flag_done}), OW'(0));
    end

`ifdef TOEPLITZ_ROUTER_PAD_EN
    cfg_pad = 1'b1;
    exp_q = '{win9(0, 0, 0, 0, 0, 1, 0, 3, 4), win9(0, 0, 0, 0, 1, 2, 3, 4, 5),
              win9(0, 0, 0, 1, 2, 0, 4, 5, 0), win9(0, 0, 1, 0, 3, 4, 0, 6, 7),
              win9(0, 1, 2, 3, 4, 5, 6, 7, 8), win9(1, 2, 0, 4, 5, 0, 7, 8, 0),
              win9(0, 3, 4, 0, 6, 7, 0, 0, 0), win9(3, 4, 5, 6, 7, 8, 0, 0, 0),
              win9(4, 5, 0, 7, 8, 0, 0, 0, 0)};
    start_cfg(3, 3, 1);
    run_stream("pad");
    cfg_pad = 1'b0;
`endif

    // Reset mid-stream, then restart from a cleared register file.
    start_cfg(4, 3, 1);
    tick();
    ctrl_start = 1'b0;
    tick();
    tick();
    check_eq("pre-reset w1", rd_data, win9(1, 2, 3, 5, 6, 7, 9, 10, 11));
    nrst = 1'b0;
    #2;
    check_eq("async reset data", rd_data, '0);
    check_eq("async reset flags", OW'({out_valid, flag_busy, flag_done, flag_cfg_err}), OW'(0));
    #2;
    nrst = 1'b1;
    tick();
    check_eq("post-reset no done", OW'({flag_done, out_valid, flag_busy}), OW'(0));
    exp_q = '{'0, '0, '0, '0};
    start_cfg(4, 3, 1);
    run_stream("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/toeplitz_router.md
# toeplitz_router

Parametrised successor to the single-flash buffer router. Holds one ifmap plane in a register file and streams im2col (Toeplitz) windows to the systolic array's nPEy rows. It adds runtime kernel width, stride 1/2, a valid/ready output handshake with backpressure, and config checking. It sits between the activation loader and the systolic array input.

## Interface
- dataSize, 8, pixel width in bits
- numRegister, 256, register-file depth in pixels
- nElementsOut, 9, output lanes (== nPEy); must be ≥ maxKernelWidth²
- maxKernelWidth, 3, largest supported kernel width
- nAddress (localparam), $clog2(numRegister), address width
- clk  in  1  clock; single clock domain
- nrst  in  1  reset, asynchronous, active-low
- wr_data  in  dataSize  pixel to store
- wr_addr  in  nAddress  pixel address, row-major y*cfg_ifmap_width+x
- wr_en  in  1  write strobe
- cfg_ifmap_width  in  16  square ifmap side
- cfg_kernel_width  in  4  kernel side k, 1..maxKernelWidth
- cfg_stride  in  2  stride s, legal values 1 or 2
- ctrl_start  in  1  start pulse, sampled in S_IDLE only
- rd_data  out  dataSize×nElementsOut  window lanes
- out_valid  out  1  window present on rd_data
- out_ready  in  1  consumer accepts window
- flag_busy  out  1  high in S_STREAM
- flag_done  out  1  one-cycle pulse after the last window handshake
- flag_cfg_err  out  1  one-cycle pulse on a rejected start

## Operation
- Register file: write on wr_en at posedge; reset clears all entries to 0. Writes during S_STREAM are performed but the window contents are then undefined.
- Output side: ow = ((cfg_ifmap_width + 2p − k) >> (s−1)) + 1. p = padding (0 unless the macro is enabled). Window count is ow², traversed row-major: ox inner, oy outer.
- Lane mapping: rd_data[j*k+i] = pixel(ox*s+i−p, oy*s+j−p) for i, j < k.
  - Lanes ≥ k² output 0.
  - Pixels outside the ifmap output 0.
  - A computed address ≥ numRegister outputs 0.
- FSM states:
  - S_IDLE: on ctrl_start, if the config is legal, go to S_STREAM. If illegal, pulse flag_cfg_err and stay in S_IDLE.
  - S_STREAM: a handshake is out_valid && out_ready. Each handshake advances the position. A handshake on the last window goes to S_IDLE and pulses flag_done.
- Illegal config:
  - k = 0
  - k > maxKernelWidth
  - s ∉ {1, 2}
  - cfg_ifmap_width + 2p < k
- ctrl_start during S_STREAM is ignored.
- Arithmetic: position counters are 16 bit; address computation uses 32-bit intermediates and is compared against numRegister before indexing.

## Timing
- Reset values: rd_data all 0, out_valid 0, flag_busy 0, flag_done 0, flag_cfg_err 0, state S_IDLE, counters 0.
- rd_data and out_valid are registered.
- ctrl_start at edge N → out_valid=1 with window (0,0) after edge N+1.
- While out_valid=1 and out_ready=0, rd_data is held stable.
- With out_ready held high, throughput is one window per cycle; total stream is ow² cycles after the first valid.
- Last handshake at edge M → after M: out_valid=0, flag_done=1 for exactly one cycle, flag_busy=0.
- flag_cfg_err is asserted the cycle after the rejected ctrl_start.
- nrst assertion mid-stream returns immediately to reset values. No done pulse is produced.

## Configuration
- TOEPLITZ_ROUTER_PAD_EN defined: adds input cfg_pad (1 bit). cfg_pad=1 sets p=1, i.e. zero-padded "same" borders for k=3. cfg_pad=0 sets p=0.
- Not defined: the cfg_pad port is absent, p is fixed at 0, and only valid convolutions are supported.

## Structure
- toeplitz_router_pkg holds:
  - the router_state_t enum (S_IDLE, S_STREAM)
  - stride encoding constants
  - the config-legality function
- Sub-module ofmap_pos_counter: tracks ox/oy with advance, clear and last outputs. It is parametrised by counter width and drives the address generator in the top.

## Test plan
- iw=4, k=3, s=1, reg[a]=a, ready=1 → 4 windows. First {0,1,2,4,5,6,8,9,10}, last {5,6,7,9,10,11,13,14,15}; flag_done one cycle after the 4th handshake.
- Same setup, out_ready low for 3 cycles on window 2 → rd_data unchanged and out_valid held; stream resumes with window 2 then window 3.
- iw=5, k=3, s=2 → 4 windows. Window 1 lanes 0..2 = {2,3,4}; window 2 lanes 0..2 = {10,11,12}.
- k=2, iw=3, s=1 → 4 windows; rd_data[4..8]=0. First window {0,1,3,4}.
- k=4 with maxKernelWidth=3 → flag_cfg_err pulse, out_valid stays 0, no flag_done. With TOEPLITZ_ROUTER_PAD_EN: iw=3, k=3, cfg_pad=1 → 9 windows, first {0,0,0,0,0,1,0,3,4}.
- nrst pulsed at window 2 of a stream → all outputs 0 and S_IDLE. A new ctrl_start then restarts from window (0,0) with the register file cleared.
